clause_vs_ls_store: RTL and testbench

- Register-based storage for one SAT bin:
  - clause array of NUM_CLAUSES rows × NUM_VARS literal slots;
  - var-state list, one entry per variable;
  - level-state list, one entry per decision level.
- Provides write-enabled bulk load/unload plus combinational per-clause satisfied/conflict flags.
- Sits inside the SAT engine as its bin-loading/unloading storage front end.

---
 rtl/sat_pkg.sv | 40 ++++
 rtl/clause_eval.sv | 38 +++
 rtl/clause_vs_ls_store.sv | 97 +++++++++
 tb/tb_clause_vs_ls_store.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared encodings for the SAT bin storage: literal/value codes, default widths
// and field offsets of var-state and level-state entries.
package sat_pkg;

    localparam logic [1:0] LIT_NONE  = 2'd0;
    localparam logic [1:0] LIT_NEG   = 2'd1;
    localparam logic [1:0] LIT_POS   = 2'd2;

    localparam logic [1:0] VAL_FREE  = 2'd0;
    localparam logic [1:0] VAL_FALSE = 2'd1;
    localparam logic [1:0] VAL_TRUE  = 2'd2;

    localparam int DEF_WIDTH_BIN_ID     = 10;
    localparam int DEF_WIDTH_LVL        = 16;
    localparam int DEF_WIDTH_VAR_STATES = 2 + 1 + DEF_WIDTH_LVL;
    localparam int DEF_WIDTH_LVL_STATES = DEF_WIDTH_BIN_ID + 1;

    // var-state entry: value[1:0], implied[2], level[18:3]
    localparam int VS_VAL_LSB  = 0;
    localparam int VS_IMPL_BIT = 2;
    localparam int VS_LVL_LSB  = 3;

    // level-state entry: has_bkt[0], dcd_bin[10:1]
    localparam int LS_BKT_BIT  = 0;
    localparam int LS_BIN_LSB  = 1;

    // Reserved code 3 falls through both checks, so it behaves as absent / unassigned.
    function automatic logic lit_true(input logic [1:0] code, input logic [1:0] val);
        return (code == LIT_POS && val == VAL_TRUE) || (code == LIT_NEG && val == VAL_FALSE);
    endfunction

    function automatic logic lit_false(input logic [1:0] code, input logic [1:0] val);
        return (code == LIT_POS && val == VAL_FALSE) || (code == LIT_NEG && val == VAL_TRUE);
    endfunction

    function automatic logic lit_present(input logic [1:0] code);
        return (code == LIT_NEG) || (code == LIT_POS);
    endfunction

endpackage

// File: rtl/clause_eval.sv
// Satisfied / conflict evaluation of one clause row against the current variable values.
module clause_eval
    import sat_pkg::*;
#(
    parameter int NUM_VARS = 8
) (
    input  logic [2*NUM_VARS-1:0] clause,
    input  logic [2*NUM_VARS-1:0] values,
    output logic                  sat,
    output logic                  conflict
);

    logic any_true;
    logic any_present;
    logic all_false;

    always_comb begin
        any_true    = 1'b0;
        any_present = 1'b0;
        all_false   = 1'b1;
        for (int j = 0; j < NUM_VARS; j++) begin
            if (lit_true(clause[2*j +: 2], values[2*j +: 2])) begin
                any_true = 1'b1;
            end
            if (lit_present(clause[2*j +: 2])) begin
                any_present = 1'b1;
                if (!lit_false(clause[2*j +: 2], values[2*j +: 2])) begin
                    all_false = 1'b0;
                end
            end
        end
    end

    // A true literal is never false, so sat and conflict are mutually exclusive.
    assign sat      = any_true;
    assign conflict = any_present && all_false;

endmodule

// File: rtl/clause_vs_ls_store.sv
// Register storage for one SAT bin: clause rows, var states and level states,
// with per-entry write enables and combinational per-row sat/conflict flags.
module clause_vs_ls_store
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = DEF_WIDTH_BIN_ID,
    parameter int WIDTH_LVL        = DEF_WIDTH_LVL,
    parameter int WIDTH_VAR_STATES = 2 + 1 + WIDTH_LVL,
    parameter int WIDTH_LVL_STATES = WIDTH_BIN_ID + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_i,
    input  logic [NUM_CLAUSES-1:0]               wr_carray_i,
    input  logic [2*NUM_VARS-1:0]                clause_i,
    input  logic [NUM_CLAUSES-1:0]               rd_carray_i,
    output logic [2*NUM_VARS-1:0]                clause_o,
    input  logic [NUM_VARS-1:0]                  wr_var_states,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    input  logic [NUM_LVLS-1:0]                  wr_lvl_states,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    output logic [NUM_CLAUSES-1:0]               clause_sat_o,
    output logic [NUM_CLAUSES-1:0]               clause_conflict_o
);

    logic [NUM_CLAUSES-1:0][2*NUM_VARS-1:0]  carray;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0]    var_states;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]    lvl_states;
    logic [2*NUM_VARS-1:0]                   values;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            carray     <= '0;
            var_states <= '0;
            lvl_states <= '0;
        end else if (clear_i) begin
            carray     <= '0;
            var_states <= '0;
            lvl_states <= '0;
        end else begin
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                if (wr_carray_i[i]) begin
                    carray[i] <= clause_i;
                end
            end
            for (int v = 0; v < NUM_VARS; v++) begin
                if (wr_var_states[v]) begin
                    var_states[v*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <=
                        vars_states_i[v*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
                end
            end
            for (int l = 0; l < NUM_LVLS; l++) begin
                if (wr_lvl_states[l]) begin
                    lvl_states[l*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <=
                        lvl_states_i[l*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
                end
            end
        end
    end

    // Multi-row read returns the OR of the selected rows.
    always_comb begin
        clause_o = '0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            if (rd_carray_i[i]) begin
                clause_o = clause_o | carray[i];
            end
        end
    end

    always_comb begin
        values = '0;
        for (int v = 0; v < NUM_VARS; v++) begin
            values[2*v +: 2] = var_states[v*WIDTH_VAR_STATES + VS_VAL_LSB +: 2];
        end
    end

    assign vars_states_o = var_states;
    assign lvl_states_o  = lvl_states;

    for (genvar i = 0; i < NUM_CLAUSES; i++) begin : g_eval
        clause_eval #(
            .NUM_VARS (NUM_VARS)
        ) u_clause_eval (
            .clause   (carray[i]),
            .values   (values),
            .sat      (clause_sat_o[i]),
            .conflict (clause_conflict_o[i])
        );
    end

endmodule

// File: tb/tb_clause_vs_ls_store.sv
// Bench for clause_vs_ls_store: directed vector table, reset corner sequences,
// then random traffic checked against an array-based reference model.
module tb_clause_vs_ls_store;

    localparam int NC = 8;
    localparam int NV = 8;
    localparam int NL = 8;
    localparam int WV = 19;
    localparam int WL = 11;

    logic              clk;
    logic              rst;
    logic              clear_i;
    logic [NC-1:0]     wr_carray_i;
    logic [2*NV-1:0]   clause_i;
    logic [NC-1:0]     rd_carray_i;
    logic [2*NV-1:0]   clause_o;
    logic [NV-1:0]     wr_var_states;
    logic [WV*NV-1:0]  vars_states_i;
    logic [WV*NV-1:0]  vars_states_o;
    logic [NL-1:0]     wr_lvl_states;
    logic [WL*NL-1:0]  lvl_states_i;
    logic [WL*NL-1:0]  lvl_states_o;
    logic [NC-1:0]     clause_sat_o;
    logic [NC-1:0]     clause_conflict_o;

    clause_vs_ls_store dut (
        .clk               (clk),
        .rst               (rst),
        .clear_i           (clear_i),
        .wr_carray_i       (wr_carray_i),
        .clause_i          (clause_i),
        .rd_carray_i       (rd_carray_i),
        .clause_o          (clause_o),
        .wr_var_states     (wr_var_states),
        .vars_states_i     (vars_states_i),
        .vars_states_o     (vars_states_o),
        .wr_lvl_states     (wr_lvl_states),
        .lvl_states_i      (lvl_states_i),
        .lvl_states_o      (lvl_states_o),
        .clause_sat_o      (clause_sat_o),
        .clause_conflict_o (clause_conflict_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [WV*NV-1:0] act, input logic [WV*NV-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2*NV-1:0] m_rows [NC];
    logic [WV-1:0]   m_vars [NV];
    logic [WL-1:0]   m_lvls [NL];

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_rows[i] = '0;
        for (int v = 0; v < NV; v++) m_vars[v] = '0;
        for (int l = 0; l < NL; l++) m_lvls[l] = '0;
    endtask

    task automatic model_edge();
        if (clear_i) begin
            model_reset();
        end else begin
            for (int i = 0; i < NC; i++) if (wr_carray_i[i]) m_rows[i] = clause_i;
            for (int v = 0; v < NV; v++) if (wr_var_states[v]) m_vars[v] = vars_states_i[v*WV +: WV];
            for (int l = 0; l < NL; l++) if (wr_lvl_states[l]) m_lvls[l] = lvl_states_i[l*WL +: WL];
        end
    endtask

    function automatic logic [2*NV-1:0] exp_clause(input logic [NC-1:0] rd);
        logic [2*NV-1:0] r = '0;
        for (int i = 0; i < NC; i++) if (rd[i]) r = r | m_rows[i];
        return r;
    endfunction

    // Count true/false/present literals per row; sat = any true, conflict = all present false.
    task automatic exp_flags(output logic [NC-1:0] sat, output logic [NC-1:0] conf);
        for (int i = 0; i < NC; i++) begin
            int n_true = 0;
            int n_false = 0;
            int n_pres = 0;
            for (int j = 0; j < NV; j++) begin
                int code = int'(m_rows[i][2*j +: 2]);
                int val  = int'(m_vars[j][1:0]);
                if (code == 1 || code == 2) n_pres++;
                if ((code == 2 && val == 2) || (code == 1 && val == 1)) n_true++;
                if ((code == 2 && val == 1) || (code == 1 && val == 2)) n_false++;
            end
            sat[i]  = (n_true > 0);
            conf[i] = (n_pres > 0) && (n_false == n_pres);
        end
    endtask

    function automatic logic [WV*NV-1:0] packed_vars();
        logic [WV*NV-1:0] r = '0;
        for (int v = 0; v < NV; v++) r[v*WV +: WV] = m_vars[v];
        return r;
    endfunction

    function automatic logic [WL*NL-1:0] packed_lvls();
        logic [WL*NL-1:0] r = '0;
        for (int l = 0; l < NL; l++) r[l*WL +: WL] = m_lvls[l];
        return r;
    endfunction

    task automatic check_all(input string tag);
        logic [NC-1:0] s;
        logic [NC-1:0] c;
        exp_flags(s, c);
        check({tag, " clause_o"}, clause_o, exp_clause(rd_carray_i));
        check({tag, " sat"}, clause_sat_o, s);
        check({tag, " conflict"}, clause_conflict_o, c);
        check({tag, " vars_states_o"}, vars_states_o, packed_vars());
        check({tag, " lvl_states_o"}, lvl_states_o, packed_lvls());
    endtask

    // ---------------- driver ----------------
    typedef struct {
        logic             clear;
        logic [NC-1:0]    wr_c;
        logic [2*NV-1:0]  clause;
        logic [NC-1:0]    rd;
        logic [NV-1:0]    wr_v;
        logic [WV*NV-1:0] vars;
        logic [NL-1:0]    wr_l;
        logic [WL*NL-1:0] lvls;
        logic [2*NV-1:0]  exp_clause;
        logic [NC-1:0]    exp_sat;
        logic [NC-1:0]    exp_conf;
    } vec_t;

    task automatic apply(input vec_t v);
        @(negedge clk);
        clear_i       = v.clear;
        wr_carray_i   = v.wr_c;
        clause_i      = v.clause;
        rd_carray_i   = v.rd;
        wr_var_states = v.wr_v;
        vars_states_i = v.vars;
        wr_lvl_states = v.wr_l;
        lvl_states_i  = v.lvls;
        @(posedge clk);
        model_edge();
        #1;
        clear_i       = 1'b0;
        wr_carray_i   = '0;
        wr_var_states = '0;
        wr_lvl_states = '0;
    endtask

    function automatic vec_t blank(input logic [NC-1:0] rd);
        vec_t v;
        v.clear = 1'b0; v.wr_c = '0; v.clause = '0; v.rd = rd;
        v.wr_v = '0; v.vars = '0; v.wr_l = '0; v.lvls = '0;
        v.exp_clause = '0; v.exp_sat = '0; v.exp_conf = '0;
        return v;
    endfunction

    vec_t vt [9];

    initial begin
        vec_t rv;

        rst = 1'b0;
        clear_i = 1'b0; wr_carray_i = '0; clause_i = '0; rd_carray_i = 8'h01;
        wr_var_states = '0; vars_states_i = '0; wr_lvl_states = '0; lvl_states_i = '0;
        model_reset();

        // ---- reset state ----
        #12;
        check("reset clause_o", clause_o, '0);
        check("reset vars_states_o", vars_states_o, '0);
        check("reset lvl_states_o", lvl_states_o, '0);
        check("reset sat", clause_sat_o, '0);
        check("reset conflict", clause_conflict_o, '0);
        @(negedge clk);
        rst = 1'b1;

        // ---- directed table ----
        vt[0] = blank(8'h01); vt[0].wr_c = 8'h01; vt[0].clause = 16'h0012; vt[0].exp_clause = 16'h0012;
        vt[1] = blank(8'h02); vt[1].wr_c = 8'h02; vt[1].clause = 16'h0048; vt[1].exp_clause = 16'h0048;
        vt[2] = blank(8'h04); vt[2].wr_c = 8'h04; vt[2].clause = 16'h0220; vt[2].exp_clause = 16'h0220;
        vt[3] = blank(8'h03); vt[3].exp_clause = 16'h005A;
        vt[4] = blank(8'hF8); vt[4].exp_clause = 16'h0000;
        vt[5] = blank(8'h01); vt[5].wr_v = 8'hFF; vt[5].vars = 152'h0000A;
        vt[5].exp_clause = 16'h0012; vt[5].exp_sat = 8'h01;
        vt[6] = blank(8'h07); vt[6].wr_v = 8'h05; vt[6].vars = (152'd2 << 38) | 152'd1;
        vt[6].exp_clause = 16'h027A; vt[6].exp_sat = 8'h04; vt[6].exp_conf = 8'h01;
        vt[7] = blank(8'h00); vt[7].wr_l = 8'h08; vt[7].lvls = 88'h00B << 33;
        vt[7].exp_sat = 8'h04; vt[7].exp_conf = 8'h01;
        vt[8] = blank(8'hFF); vt[8].clear = 1'b1; vt[8].wr_l = 8'hFF; vt[8].lvls = '1;
        vt[8].wr_c = 8'hFF; vt[8].clause = 16'hAAAA;

        for (int k = 0; k < 9; k++) begin
            apply(vt[k]);
            check($sformatf("vec%0d clause_o", k), clause_o, vt[k].exp_clause);
            check($sformatf("vec%0d sat", k), clause_sat_o, vt[k].exp_sat);
            check($sformatf("vec%0d conflict", k), clause_conflict_o, vt[k].exp_conf);
            check_all($sformatf("vec%0d model", k));
            if (k == 5) check("vec5 vars slice0", vars_states_o, 152'h0000A);
            if (k == 7) check("vec7 lvl slice3 only", lvl_states_o, 88'h00B << 33);
            if (k == 8) begin
                check("clear vars", vars_states_o, '0);
                check("clear lvls", lvl_states_o, '0);
            end
        end

        // ---- async reset between edges after loads ----
        rv = blank(8'hFF); rv.wr_c = 8'hFF; rv.clause = 16'h0006;
        rv.wr_v = 8'hFF; rv.vars = {8{19'h00002}}; rv.wr_l = 8'hFF; rv.lvls = {8{11'h7FF}};
        apply(rv);
        check("preload clause_o", clause_o, 16'h0006);
        check("preload sat", clause_sat_o, 8'hFF);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async rst clause_o", clause_o, '0);
        check("async rst vars", vars_states_o, '0);
        check("async rst lvls", lvl_states_o, '0);
        check("async rst sat", clause_sat_o, '0);

        // ---- write held during reset is ignored, lands after release ----
        clause_i = 16'h0002; wr_carray_i = 8'hFF;
        vars_states_i = {8{19'h00001}}; wr_var_states = 8'hFF;
        @(posedge clk); #1;
        check("rst mid-write clause_o", clause_o, '0);
        check("rst mid-write vars", vars_states_o, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        wr_carray_i = '0; wr_var_states = '0;
        check("post-rst write clause_o", clause_o, 16'h0002);
        check("post-rst write conflict", clause_conflict_o, 8'hFF);
        check_all("post-rst");

        // ---- randomized traffic ----
        for (int n = 0; n < 300; n++) begin
            rv = blank(8'($urandom));
            rv.clear = ($urandom_range(0, 29) == 0);
            rv.wr_c  = ($urandom_range(0, 1) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom);
            for (int j = 0; j < NV; j++) begin
                rv.clause[2*j +: 2] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            end
            rv.wr_v = 8'($urandom);
            for (int v = 0; v < NV; v++) rv.vars[v*WV +: WV] = 19'($urandom);
            rv.wr_l = 8'($urandom);
            for (int l = 0; l < NL; l++) rv.lvls[l*WL +: WL] = 11'($urandom);
            apply(rv);
            check_all($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
